// File: rtl/load_store_unit.sv
// Load/store unit bridging byte/halfword requests onto a byte-or-halfword memory port.
// Unaligned halfwords become two byte accesses (high byte at the lower address).
module load_store_unit #(
  parameter int MEM_BYTES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic        req_size,
  input  logic        req_signed,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic        resp_err,
  output logic        wmem,
  output logic [15:0] DAddress,
  output logic [15:0] DataIn,
  output logic        memc,
  input  logic [15:0] DataOut
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  localparam logic [16:0] MEM_LIMIT = 17'(MEM_BYTES);

  state_t      state_reg, state_next;
  logic [15:0] addr_reg, addr_next;
  logic [15:0] wdata_reg, wdata_next;
  logic        we_reg, we_next;
  logic        size_reg, size_next;
  logic        signed_reg, signed_next;
  logic        err_reg, err_next;
  logic        split_reg, split_next;
  logic [7:0]  hi_reg, hi_next;

  logic        req_ready_reg, req_ready_next;
  logic        resp_valid_reg, resp_valid_next;
  logic [15:0] resp_rdata_reg, resp_rdata_next;
  logic        resp_err_reg, resp_err_next;
  logic        wmem_reg, wmem_next;
  logic        memc_reg, memc_next;
  logic [15:0] daddr_reg, daddr_next;
  logic [15:0] din_reg, din_next;

  logic [16:0] req_addr_ext;
  logic        req_err;
  logic [15:0] byte_ext;

  assign req_addr_ext = {1'b0, req_addr};
  assign req_err = (req_addr_ext >= MEM_LIMIT) ||
                   (req_size && ((req_addr_ext + 17'd1) >= MEM_LIMIT));
  assign byte_ext = signed_reg ? {{8{DataOut[7]}}, DataOut[7:0]} : {8'h00, DataOut[7:0]};

  always_comb begin
    state_next      = state_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    we_next         = we_reg;
    size_next       = size_reg;
    signed_next     = signed_reg;
    err_next        = err_reg;
    split_next      = split_reg;
    hi_next         = hi_reg;
    req_ready_next  = 1'b0;
    resp_valid_next = 1'b0;
    resp_rdata_next = resp_rdata_reg;
    resp_err_next   = resp_err_reg;
    wmem_next       = 1'b0;
    memc_next       = 1'b0;
    daddr_next      = 16'h0000;
    din_next        = 16'h0000;

    case (state_reg)
      IDLE: begin
        req_ready_next = 1'b1;
        if (req_valid && req_ready_reg) begin
          state_next     = ACC0;
          req_ready_next = 1'b0;
          addr_next      = req_addr;
          wdata_next     = req_wdata;
          we_next        = req_we;
          size_next      = req_size;
          signed_next    = req_signed;
          err_next       = req_err;
          split_next     = req_size & req_addr[0] & ~req_err;
          // Outputs are registered, so the first access is set up on the accept edge.
          if (!req_err) begin
            daddr_next = req_addr;
            memc_next  = req_size & ~req_addr[0];
            wmem_next  = req_we;
            if (req_we) begin
              if (!req_size)
                din_next = {8'h00, req_wdata[7:0]};
              else if (req_addr[0])
                din_next = {8'h00, req_wdata[15:8]};
              else
                din_next = req_wdata;
            end
          end
        end
      end

      ACC0: begin
        if (err_reg) begin
          state_next      = RESP;
          resp_valid_next = 1'b1;
          resp_rdata_next = 16'h0000;
          resp_err_next   = 1'b1;
        end else if (split_reg) begin
          state_next = ACC1;
          hi_next    = DataOut[7:0];
          daddr_next = addr_reg + 16'd1;
          wmem_next  = we_reg;
          if (we_reg)
            din_next = {8'h00, wdata_reg[7:0]};
        end else begin
          state_next      = RESP;
          resp_valid_next = 1'b1;
          resp_err_next   = 1'b0;
          if (we_reg)
            resp_rdata_next = 16'h0000;
          else if (size_reg)
            resp_rdata_next = DataOut;
          else
            resp_rdata_next = byte_ext;
        end
      end

      ACC1: begin
        state_next      = RESP;
        resp_valid_next = 1'b1;
        resp_err_next   = 1'b0;
        resp_rdata_next = we_reg ? 16'h0000 : {hi_reg, DataOut[7:0]};
      end

      RESP: begin
        state_next     = IDLE;
        req_ready_next = 1'b1;
      end

      default: begin
        state_next     = IDLE;
        req_ready_next = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      addr_reg       <= 16'h0000;
      wdata_reg      <= 16'h0000;
      we_reg         <= 1'b0;
      size_reg       <= 1'b0;
      signed_reg     <= 1'b0;
      err_reg        <= 1'b0;
      split_reg      <= 1'b0;
      hi_reg         <= 8'h00;
      req_ready_reg  <= 1'b1;
      resp_valid_reg <= 1'b0;
      resp_rdata_reg <= 16'h0000;
      resp_err_reg   <= 1'b0;
      wmem_reg       <= 1'b0;
      memc_reg       <= 1'b0;
      daddr_reg      <= 16'h0000;
      din_reg        <= 16'h0000;
    end else begin
      state_reg      <= state_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      we_reg         <= we_next;
      size_reg       <= size_next;
      signed_reg     <= signed_next;
      err_reg        <= err_next;
      split_reg      <= split_next;
      hi_reg         <= hi_next;
      req_ready_reg  <= req_ready_next;
      resp_valid_reg <= resp_valid_next;
      resp_rdata_reg <= resp_rdata_next;
      resp_err_reg   <= resp_err_next;
      wmem_reg       <= wmem_next;
      memc_reg       <= memc_next;
      daddr_reg      <= daddr_next;
      din_reg        <= din_next;
    end
  end

  assign req_ready  = req_ready_reg;
  assign resp_valid = resp_valid_reg;
  assign resp_rdata = resp_rdata_reg;
  assign resp_err   = resp_err_reg;
  assign wmem       = wmem_reg;
  assign memc       = memc_reg;
  assign DAddress   = daddr_reg;
  assign DataIn     = din_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: byte-addressed memory model plus
// scoreboards for expected memory writes and expected responses.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic        req_size;
  logic        req_signed;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic        resp_err;
  logic        wmem;
  logic [15:0] DAddress;
  logic [15:0] DataIn;
  logic        memc;
  logic [15:0] DataOut;

  int total = 0;
  int bad   = 0;

  logic [7:0]  mem [64] = '{default: 8'h00};
  logic [32:0] wr_q[$];    // {memc, addr, data}
  logic [16:0] resp_q[$];  // {err, rdata}

  load_store_unit #(.MEM_BYTES(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .wmem(wmem), .DAddress(DAddress), .DataIn(DataIn),
    .memc(memc), .DataOut(DataOut)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Big-endian memory: halfword at a is {mem[a], mem[a+1]}.
  always_comb begin
    DataOut = 16'h0000;
    if (memc) begin
      if (DAddress < 16'd63)
        DataOut = {mem[DAddress[5:0]], mem[DAddress[5:0] + 6'd1]};
    end else if (DAddress < 16'd64) begin
      DataOut = {8'h00, mem[DAddress[5:0]]};
    end
  end

  always @(posedge clk) begin
    if (wmem) begin
      if (memc && DAddress < 16'd63) begin
        mem[DAddress[5:0]]        <= DataIn[15:8];
        mem[DAddress[5:0] + 6'd1] <= DataIn[7:0];
      end else if (!memc && DAddress < 16'd64) begin
        mem[DAddress[5:0]] <= DataIn[7:0];
      end
    end
  end

  // Write monitor
  always @(negedge clk) begin
    if (wmem) begin
      if (wr_q.size() == 0) begin
        check("unexpected_write", {15'h0, memc, DAddress}, 32'hFFFF_FFFF);
      end else begin
        logic [32:0] w;
        w = wr_q.pop_front();
        $display("write addr=%h data=%h memc=%0d", DAddress, DataIn, memc);
        check("wr_addr", {16'h0, DAddress}, {16'h0, w[31:16]});
        check("wr_data", {16'h0, DataIn}, {16'h0, w[15:0]});
        check("wr_memc", {31'h0, memc}, {31'h0, w[32]});
      end
    end
  end

  // Response monitor
  always @(negedge clk) begin
    if (resp_valid) begin
      if (resp_q.size() == 0) begin
        check("unexpected_resp", 32'h1, 32'h0);
      end else begin
        logic [16:0] r;
        r = resp_q.pop_front();
        $display("resp rdata=%h err=%0d", resp_rdata, resp_err);
        check("resp_rdata", {16'h0, resp_rdata}, {16'h0, r[15:0]});
        check("resp_err", {31'h0, resp_err}, {31'h0, r[16]});
      end
    end
  end

  task automatic push_wr(input logic [15:0] a, input logic [15:0] d, input logic mc);
    wr_q.push_back({mc, a, d});
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", {31'h0, req_ready}, 32'h1);
  endtask

  task automatic do_req(input logic we, input logic sz, input logic sg,
                        input logic [15:0] a, input logic [15:0] wd,
                        input logic [15:0] exp_rdata, input logic exp_err,
                        input int exp_lat);
    int n;
    wait_ready();
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    resp_q.push_back({exp_err, exp_rdata});
    $display("req we=%0d size=%0d signed=%0d addr=%h wdata=%h", we, sz, sg, a, wd);
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resp_valid && n < 9);
    check("latency", n, exp_lat);
    check("resp_idle_mem_bus", {wmem, memc, DAddress, DataIn[13:0]}, 32'h0);
  endtask

  initial begin
    int accepts;
    int last_i;
    rst_n = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 1'b0;
    req_signed = 1'b0; req_addr = 16'h0; req_wdata = 16'h0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_ready", {31'h0, req_ready}, 32'h1);
    check("rst_outputs", {resp_valid, resp_err, wmem, memc, resp_rdata, 12'h0}, 32'h0);
    check("rst_bus", {DAddress, DataIn}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Aligned halfword store/load
    push_wr(16'h0004, 16'hBEEF, 1'b1);
    do_req(1'b1, 1'b1, 1'b0, 16'h0004, 16'hBEEF, 16'h0000, 1'b0, 2);
    do_req(1'b0, 1'b1, 1'b0, 16'h0004, 16'h0000, 16'hBEEF, 1'b0, 2);

    // Split halfword store/load
    push_wr(16'h0007, 16'h0012, 1'b0);
    push_wr(16'h0008, 16'h0034, 1'b0);
    do_req(1'b1, 1'b1, 1'b0, 16'h0007, 16'h1234, 16'h0000, 1'b0, 3);
    do_req(1'b0, 1'b1, 1'b0, 16'h0007, 16'h0000, 16'h1234, 1'b0, 3);
    do_req(1'b0, 1'b1, 1'b0, 16'h0008, 16'h0000, 16'h3400, 1'b0, 2);

    // Byte store then sign/zero-extended loads; halfword load ignores signed
    push_wr(16'h0010, 16'h0085, 1'b0);
    do_req(1'b1, 1'b0, 1'b0, 16'h0010, 16'h1285, 16'h0000, 1'b0, 2);
    do_req(1'b0, 1'b0, 1'b1, 16'h0010, 16'h0000, 16'hFF85, 1'b0, 2);
    do_req(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0085, 1'b0, 2);
    do_req(1'b0, 1'b1, 1'b1, 16'h0010, 16'h0000, 16'h8500, 1'b0, 2);

    // Range errors (no writes pushed, so any wmem is flagged)
    do_req(1'b1, 1'b1, 1'b0, 16'h003F, 16'hAAAA, 16'h0000, 1'b1, 2);
    do_req(1'b1, 1'b0, 1'b0, 16'h0040, 16'h0055, 16'h0000, 1'b1, 2);
    do_req(1'b0, 1'b1, 1'b0, 16'h003F, 16'h0000, 16'h0000, 1'b1, 2);
    do_req(1'b0, 1'b0, 1'b0, 16'h003F, 16'h0000, 16'h0000, 1'b0, 2);
    do_req(1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 2);

    // Reset during ACC1 of a split store: only the first byte lands
    push_wr(16'h0021, 16'h00A5, 1'b0);
    wait_ready();
    req_valid = 1'b1; req_we = 1'b1; req_size = 1'b1; req_signed = 1'b0;
    req_addr = 16'h0021; req_wdata = 16'hA5C3;
    $display("req we=1 size=1 addr=0021 wdata=a5c3 (reset in ACC1)");
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_ready", {31'h0, req_ready}, 32'h1);
    check("abort_outputs", {resp_valid, resp_err, wmem, memc, resp_rdata, 12'h0}, 32'h0);
    check("abort_bus", {DAddress, DataIn}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_ready_after", {31'h0, req_ready}, 32'h1);
    check("abort_mem21", {24'h0, mem[6'h21]}, 32'h0000_00A5);
    check("abort_mem22", {24'h0, mem[6'h22]}, 32'h0);
    do_req(1'b0, 1'b1, 1'b0, 16'h0021, 16'h0000, 16'hA500, 1'b0, 3);

    // Back-to-back: req_valid held high, ready every third cycle
    wait_ready();
    req_valid = 1'b1; req_we = 1'b0; req_size = 1'b0; req_signed = 1'b0;
    req_addr = 16'h0010; req_wdata = 16'h0;
    accepts = 0;
    last_i = -3;
    for (int i = 0; i < 15; i++) begin
      if (i > 0) @(negedge clk);
      if (req_ready) begin
        check("b2b_spacing", i - last_i, 3);
        last_i = i;
        accepts++;
        resp_q.push_back({1'b0, 16'h0085});
        $display("req b2b load byte addr=0010 cycle=%0d", i);
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b_accepts", accepts, 5);
    repeat (6) @(negedge clk);

    check("resp_q_drained", resp_q.size(), 0);
    check("wr_q_drained", wr_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have exactly one clock and one reset: reset is asynchronous and active-low.
REQ-002 The block SHALL have the ports: clk  in  1  rising-edge clock.
REQ-003 The block SHALL have the port: rst_n  in  1  asynchronous active-low reset.
REQ-004 The block SHALL have the ports: req_valid  in  1; req_ready  out  1; req_we  in  1 (1 store, 0 load); req_size  in  1 (0 byte, 1 halfword); req_signed  in  1 (sign-extend byte loads); req_addr  in  16 (byte address); req_wdata  in  16.
REQ-005 The block SHALL have the ports: resp_valid  out  1; resp_rdata  out  16; resp_err  out  1.
REQ-006 The block SHALL have the memory-side ports: wmem  out  1 (1 write); DAddress  out  16; DataIn  out  16; memc  out  1 (0 byte, 1 halfword); DataOut  in  16 (combinational read data).
REQ-007 The block SHALL have one parameter: MEM_BYTES, default 64, giving the number of addressable bytes.

Function
REQ-008 The FSM SHALL have the states IDLE, ACC0, ACC1, RESP and SHALL use registered outputs only.
REQ-009 req_ready SHALL be 1 only in IDLE; a request SHALL be accepted when req_valid and req_ready are both high at a clock edge, and all req_* fields SHALL be captured at that edge.
REQ-010 Accepting a request SHALL move IDLE->ACC0; a non-accepting edge in IDLE SHALL keep the FSM in IDLE.
REQ-011 Byte access: in ACC0 the block SHALL drive memc=0, DAddress=addr, and for a store wmem=1 with DataIn={8'h00,wdata[7:0]}; the next state SHALL be RESP.
REQ-012 Aligned halfword (addr[0]=0): in ACC0 the block SHALL drive memc=1, DAddress=addr, and for a store wmem=1 with DataIn=wdata; the next state SHALL be RESP.
REQ-013 Unaligned halfword (addr[0]=1) SHALL be split into two byte accesses. ACC0 SHALL access addr carrying wdata[15:8], and ACC1 SHALL access addr+1 carrying wdata[7:0]. Both SHALL use memc=0, and the sequence SHALL be ACC0->ACC1->RESP.
REQ-014 Load data SHALL be sampled from DataOut at the end of each ACC cycle. Aligned halfword: rdata=DataOut. Byte: rdata=DataOut[7:0] zero-extended, or sign-extended when req_signed=1. Split halfword: rdata={DataOut@ACC0[7:0], DataOut@ACC1[7:0]} (high byte at the lower address). req_signed SHALL be ignored for halfwords.
REQ-015 Range error SHALL be raised when addr>=MEM_BYTES, or when a halfword satisfies addr+1>=MEM_BYTES. On error the FSM SHALL go IDLE->ACC0->RESP with wmem=0 and memc=0 in ACC0, SHALL perform no memory write, and SHALL return resp_err=1 and resp_rdata=0.
REQ-016 RESP SHALL last exactly one cycle with resp_valid=1, then return to IDLE. resp_rdata and resp_err SHALL hold until the next RESP. Stores SHALL return resp_rdata=0.
REQ-017 Latency from the accept edge to resp_valid SHALL be 2 cycles for byte, aligned halfword and error accesses, and 3 cycles for a split halfword. Maximum throughput SHALL be one request per 3 cycles (per 4 when split).
REQ-018 Outside ACC0/ACC1, wmem, memc, DAddress and DataIn SHALL all be 0.
REQ-019 wmem SHALL be high for exactly one cycle per memory write, with DAddress and DataIn stable for that whole cycle.
REQ-020 req_valid SHALL be ignored outside IDLE; there SHALL be no queuing.

Reset
REQ-021 Asserting rst_n low SHALL force, asynchronously, state=IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, wmem=0, memc=0, DAddress=0, DataIn=0.
REQ-022 Reset asserted during ACC0 or ACC1 SHALL abort the access immediately with wmem low, and no response SHALL be produced for the aborted request.
REQ-023 After rst_n deasserts, the first request SHALL be acceptable at the first rising edge.

Verification
REQ-024 Aligned halfword: store addr=0x0004, wdata=0xBEEF, then load addr=0x0004 -> one write cycle with memc=1, DataIn=0xBEEF; the load returns resp_rdata=0xBEEF, resp_err=0, resp_valid 2 cycles after accept.
REQ-025 Split halfword: store addr=0x0007, wdata=0x1234 -> two write cycles: (0x0007, DataIn[7:0]=0x12) then (0x0008, 0x34); a load at 0x0007 returns 0x1234 with resp_valid 3 cycles after accept.
REQ-026 Byte sign/zero extension: memory byte 0x85 at 0x0010 -> a signed byte load returns 0xFF85, and an unsigned byte load returns 0x0085.
REQ-027 Range error: store a halfword at 0x003F, or a byte at 0x0040, with MEM_BYTES=64 -> wmem never high, resp_err=1, resp_rdata=0.
REQ-028 Reset mid-split: assert rst_n in the ACC1 cycle of a split store -> only the first byte is written, no resp_valid, and all outputs are at reset values.
REQ-029 Back-to-back: hold req_valid high continuously -> req_ready pulses once per 3 cycles and every request gets exactly one resp_valid.
